// File: rtl/cnn_lenet_mul_pkg.sv
// Shared configuration and output-stage record for the LeNet multiplier arbiter.
package cnn_lenet_mul_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int A_W_DEF     = 8;
  localparam int B_W_DEF     = 10;
  localparam int P_W_DEF     = 17;
  localparam int ID_W_DEF    = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

  typedef struct packed {
    logic                vld;
    logic [ID_W_DEF-1:0] id;
    logic [P_W_DEF-1:0]  data;
    logic                ovf;
  } out_stage_t;

endpackage

// File: rtl/cnn_lenet_mul_8ns_10ns_17_1_1.sv
// Combinational unsigned multiplier; output is wide enough for the full product.
module cnn_lenet_mul_8ns_10ns_17_1_1 #(
  parameter int A_W = 8,
  parameter int B_W = 10,
  parameter int O_W = 18
) (
  input  logic [A_W-1:0] din0,
  input  logic [B_W-1:0] din1,
  output logic [O_W-1:0] dout
);

  assign dout = O_W'(din0) * O_W'(din1);

endmodule

// File: rtl/cnn_lenet_mul_arb.sv
// Round-robin arbiter sharing one multiplier among NUM_REQ requesters,
// with a single registered output stage and a completed-result counter.
module cnn_lenet_mul_arb
  import cnn_lenet_mul_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int P_W     = P_W_DEF
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [P_W-1:0]         rsp_data,
  output logic                   rsp_ovf,
  output logic [31:0]            op_cnt
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FULL_W = A_W + B_W;

  out_stage_t         out_q, out_d;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_d;
  logic [31:0]        op_cnt_q;

  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic               can_accept;
  logic               xfer;
  logic               rsp_hs;
  logic [A_W-1:0]     a_sel;
  logic [B_W-1:0]     b_sel;
  logic [FULL_W-1:0]  prod_full;

  // Search starts at rr_ptr and wraps; only req_valid is looked at, never operands.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  assign can_accept = !out_q.vld || rsp_ready[out_q.id];
  assign xfer       = gnt_vld && can_accept;
  assign rsp_hs     = out_q.vld && rsp_ready[out_q.id];

  // Reset gating keeps req_ready low while ap_rst_n is held, regardless of req_valid.
  assign req_ready  = (xfer && ap_rst_n) ? (NUM_REQ'(1) << gnt_id) : '0;

  assign a_sel = req_a[gnt_id*A_W +: A_W];
  assign b_sel = req_b[gnt_id*B_W +: B_W];

  cnn_lenet_mul_8ns_10ns_17_1_1 #(
    .A_W (A_W),
    .B_W (B_W),
    .O_W (FULL_W)
  ) u_mul (
    .din0 (a_sel),
    .din1 (b_sel),
    .dout (prod_full)
  );

  always_comb begin
    out_d    = out_q;
    rr_ptr_d = rr_ptr;
    if (xfer) begin
      out_d.vld  = 1'b1;
      out_d.id   = gnt_id;
      out_d.data = prod_full[P_W-1:0];
      out_d.ovf  = |prod_full[FULL_W-1:P_W];
      rr_ptr_d   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (rsp_hs) begin
      out_d.vld  = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_q    <= '0;
      rr_ptr   <= '0;
      op_cnt_q <= '0;
    end else begin
      out_q  <= out_d;
      rr_ptr <= rr_ptr_d;
      if (rsp_hs) op_cnt_q <= op_cnt_q + 32'd1;
    end
  end

  assign rsp_valid = out_q.vld ? (NUM_REQ'(1) << out_q.id) : '0;
  assign rsp_data  = out_q.data;
  assign rsp_ovf   = out_q.ovf;
  assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_cnn_lenet_mul_arb.sv
// Self-checking bench for cnn_lenet_mul_arb against a transaction-level reference model.
module tb_cnn_lenet_mul_arb;

  localparam int NREQ = 4;
  localparam longint PMOD = 131072;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [31:0]     req_a;
  logic [39:0]     req_b;
  logic [3:0]      rsp_valid;
  logic [3:0]      rsp_ready;
  logic [16:0]     rsp_data;
  logic            rsp_ovf;
  logic [31:0]     op_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state: held result, next requester to favour, completed count
  bit          m_vld;
  int          m_id;
  longint      m_data;
  bit          m_ovf;
  int          m_ptr;
  logic [31:0] m_cnt;

  always #5 ap_clk = ~ap_clk;

  cnn_lenet_mul_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .op_cnt    (op_cnt)
  );

  function automatic void model_reset();
    m_vld = 0; m_id = 0; m_data = 0; m_ovf = 0; m_ptr = 0; m_cnt = '0;
  endfunction

  function automatic int m_grant();
    if (m_vld && !rsp_ready[m_id]) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int g;
    g = m_grant();
    return (g >= 0) ? 4'(1 << g) : 4'b0000;
  endfunction

  function automatic logic [3:0] m_rspv();
    return m_vld ? 4'(1 << m_id) : 4'b0000;
  endfunction

  function automatic void model_edge();
    int g;
    bit hs;
    longint p;
    g  = m_grant();
    hs = m_vld && rsp_ready[m_id];
    if (hs) m_cnt = m_cnt + 32'd1;
    if (g >= 0) begin
      p = longint'(req_a[g*8 +: 8]) * longint'(req_b[g*10 +: 10]);
      m_data = p % PMOD;
      m_ovf  = (p >= PMOD);
      m_id   = g;
      m_vld  = 1;
      m_ptr  = (g + 1) % NREQ;
    end else if (hs) begin
      m_vld = 0;
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*8 +: 8]   = 8'(a);
    req_b[i*10 +: 10] = 10'(b);
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 4'b1111;
    req_a = '0; req_b = '0;
    model_reset();
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (op_cnt !== 32'd0) begin errors++; $display("FAIL reset_op_cnt got %0d exp 0", op_cnt); end
    req_valid = 4'b0000;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 4'b0001; set_op(0, 12, 34); rsp_ready = 4'b1111;
    @(negedge ap_clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_first_grant got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    @(negedge ap_clk);
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b exp 0001", rsp_valid); end
    checks++; if (rsp_data !== 17'd408) begin errors++; $display("FAIL single_rsp_data got %0d exp 408", rsp_data); end
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL single_rsp_ovf got %b exp 0", rsp_ovf); end
    checks++; if (op_cnt !== 32'd0) begin errors++; $display("FAIL single_cnt_before got %0d exp 0", op_cnt); end
    tick();
    @(negedge ap_clk);
    checks++; if (op_cnt !== 32'd1) begin errors++; $display("FAIL single_cnt_after got %0d exp 1", op_cnt); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_cleared got %b exp 0000", rsp_valid); end
    tick();
  endtask

  task automatic test_overflow();
    req_valid = 4'b0100; set_op(2, 255, 1023); rsp_ready = 4'b1111;
    @(negedge ap_clk);
    tick();
    req_valid = 4'b0000;
    @(negedge ap_clk);
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL ovf_rsp_valid got %b exp 0100", rsp_valid); end
    checks++; if (rsp_data !== 17'd129793) begin errors++; $display("FAIL ovf_rsp_data got %0d exp 129793", rsp_data); end
    checks++; if (rsp_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", rsp_ovf); end
    tick();
  endtask

  task automatic test_round_robin();
    int prev;
    int g;
    prev = -1;
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 1023)));
      @(negedge ap_clk);
      g = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
      checks++; if (req_ready !== m_ready()) begin errors++; $display("FAIL rr_grant cycle %0d got %b exp %b", c, req_ready, m_ready()); end
      if (prev >= 0) begin
        checks++; if (g != (prev + 1) % NREQ) begin errors++; $display("FAIL rr_order cycle %0d got %0d exp %0d", c, g, (prev + 1) % NREQ); end
      end
      if (c > 0) begin
        checks++; if (rsp_valid !== m_rspv() || rsp_valid === 4'b0000) begin errors++; $display("FAIL rr_no_bubble cycle %0d got %b exp %b", c, rsp_valid, m_rspv()); end
        checks++; if (rsp_data !== 17'(m_data) || rsp_ovf !== m_ovf) begin errors++; $display("FAIL rr_data cycle %0d got %0d/%b exp %0d/%b", c, rsp_data, rsp_ovf, m_data, m_ovf); end
      end
      prev = g;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] held;
    req_valid = 4'b0010; set_op(1, 200, 900); rsp_ready = 4'b1111;
    @(negedge ap_clk);
    checks++; if (req_ready !== m_ready()) begin errors++; $display("FAIL bp_first_grant got %b exp %b", req_ready, m_ready()); end
    tick();
    req_valid = 4'b1000; set_op(3, 99, 77); rsp_ready = 4'b1101;
    held = 17'((200 * 900) % PMOD);
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_low cycle %0d got %b exp 0000", c, req_ready); end
      checks++; if (rsp_valid !== 4'b0010 || rsp_data !== held) begin errors++; $display("FAIL bp_hold cycle %0d got %b/%0d exp 0010/%0d", c, rsp_valid, rsp_data, held); end
      tick();
    end
    rsp_ready = 4'b1111;
    @(negedge ap_clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_accept got %b exp 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    @(negedge ap_clk);
    checks++; if (rsp_valid !== 4'b1000 || rsp_data !== 17'd7623) begin errors++; $display("FAIL bp_reload got %b/%0d exp 1000/7623", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_random();
    int waitc [NREQ];
    logic [3:0] nxt_valid;
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 1023)));
      rsp_ready = 4'($urandom()) | 4'($urandom());
      @(negedge ap_clk);
      checks++; if (req_ready !== m_ready()) begin errors++; $display("FAIL rand_req_ready cycle %0d got %b exp %b", c, req_ready, m_ready()); end
      checks++; if (rsp_valid !== m_rspv()) begin errors++; $display("FAIL rand_rsp_valid cycle %0d got %b exp %b", c, rsp_valid, m_rspv()); end
      checks++; if (op_cnt !== m_cnt) begin errors++; $display("FAIL rand_op_cnt cycle %0d got %0d exp %0d", c, op_cnt, m_cnt); end
      if (m_vld) begin
        checks++; if (rsp_data !== 17'(m_data) || rsp_ovf !== m_ovf) begin errors++; $display("FAIL rand_data cycle %0d got %0d/%b exp %0d/%b", c, rsp_data, rsp_ovf, m_data, m_ovf); end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || req_ready[i]) waitc[i] = 0;
        else if (req_ready != 4'b0000) begin
          waitc[i]++;
          checks++; if (waitc[i] > NREQ - 1) begin errors++; $display("FAIL rand_starve req %0d waited %0d exp <= %0d", i, waitc[i], NREQ - 1); end
        end
      end
      nxt_valid = (req_valid & ~req_ready) | (4'($urandom()) & 4'($urandom()));
      tick();
      req_valid = nxt_valid;
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0000; rsp_ready = 4'b1111;
    tick(); tick();
    req_valid = 4'b0001; set_op(0, 5, 6); rsp_ready = 4'b0000;
    tick();
    req_valid = 4'b0000;
    @(negedge ap_clk);
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rstmid_pre got %b exp 0001", rsp_valid); end
    #2;
    ap_rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (op_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_op_cnt got %0d exp 0", op_cnt); end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    @(negedge ap_clk);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_no_resp got %b exp 0000", rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_rr_ptr got %b exp 0001", req_ready); end
  endtask

  task automatic test_wrap();
    tick();
    req_valid = 4'b0000;
    force dut.op_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.op_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    @(negedge ap_clk);
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL wrap_pending got %b exp 0001", rsp_valid); end
    tick();
    @(negedge ap_clk);
    checks++; if (op_cnt !== 32'd0) begin errors++; $display("FAIL wrap_op_cnt got %0d exp 0", op_cnt); end
  endtask

  initial begin
    fork
      begin
        #500000;
        $display("FAIL timeout sim time %0t exp finish earlier", $time);
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_lenet_mul_arb.md
CNN_LENET_MUL_ARB -- requirements
Module: cnn_lenet_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier.
REQ-002 SHALL have parameter A_W, default 8, unsigned operand A width.
REQ-003 SHALL have parameter B_W, default 10, unsigned operand B width.
REQ-004 SHALL have parameter P_W, default 17, result width.
REQ-005 SHALL have ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_a  in  NUM_REQ*A_W  packed operand A; requester i occupies slice i.
- req_b  in  NUM_REQ*B_W  packed operand B; requester i occupies slice i.
- rsp_valid  out  NUM_REQ  one-hot result valid; identifies the destination requester.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  P_W  product, shared by all requesters.
- rsp_ovf  out  1  full product did not fit in P_W bits.
- op_cnt  out  32  count of completed results; wraps.

Function
REQ-006 SHALL keep a single output stage: out_vld, out_id, out_data, out_ovf.
REQ-007 SHALL define can_accept = !out_vld | rsp_ready[out_id].
REQ-008 SHALL grant at most one requester per cycle, by round-robin from pointer rr_ptr over requesters with req_valid set.
REQ-009 SHALL drive req_ready one-hot to the granted requester only when can_accept is true; otherwise req_ready SHALL be all zero.
REQ-010 SHALL treat a transfer as req_valid[i] & req_ready[i]; req_ready SHALL NOT depend combinationally on its own requester's req_a or req_b.
REQ-011 On a transfer, SHALL load out_data = (a*b) mod 2^P_W, out_ovf = (a*b >= 2^P_W), out_id = i, out_vld = 1 at the same edge; latency is 1 cycle.
REQ-012 SHALL compute the full product at A_W+B_W bits before truncation; for defaults the maximum is 255*1023 = 260865, which sets rsp_ovf.
REQ-013 SHALL drive rsp_valid = out_vld ? onehot(out_id) : 0, and drive rsp_data and rsp_ovf from the output stage.
REQ-014 SHALL hold rsp_valid and rsp_data stable until rsp_ready[out_id] is seen.
REQ-015 On a response handshake with no simultaneous transfer, SHALL clear out_vld.
REQ-016 On a response handshake with a simultaneous transfer, SHALL reload the output stage with no bubble, sustaining 1 result per cycle.
REQ-017 After a grant to requester i, SHALL set rr_ptr = (i+1) mod NUM_REQ; with no grant, rr_ptr SHALL be unchanged.
REQ-018 Starvation bound: a requester holding req_valid SHALL be granted within NUM_REQ transfers.
REQ-019 SHALL increment op_cnt on each response handshake, wrapping from 2^32-1 to 0.
REQ-020 SHALL ignore rsp_ready bits other than rsp_ready[out_id].

Reset
REQ-021 Assertion of ap_rst_n low SHALL immediately clear out_vld, out_id, out_data, out_ovf, rr_ptr and op_cnt to 0, so that rsp_valid = 0 and req_ready = 0.
REQ-022 Reset asserted mid-operation SHALL discard any held result without generating a response.
REQ-023 SHALL release from reset synchronously to ap_clk; the first grant is possible in the first cycle after deassertion.

Structure
REQ-024 SHALL place NUM_REQ, A_W, B_W, P_W defaults and the output-stage record typedef in shared package cnn_lenet_mul_pkg.
REQ-025 SHALL instantiate exactly one combinational multiplier sub-module, cnn_lenet_mul_8ns_10ns_17_1_1, widened to A_W+B_W output for the overflow check.
REQ-026 SHALL keep the round-robin arbiter inside this module; it SHALL NOT be a separate module.

Verification
REQ-027 Single request: req_valid=0001, a=12, b=34 -> next cycle rsp_valid=0001, rsp_data=408, rsp_ovf=0, op_cnt=1 after handshake.
REQ-028 Overflow: a=255, b=1023 -> rsp_data=260865-131072=129793, rsp_ovf=1.
REQ-029 Round-robin under contention: all four requesters valid continuously, rsp_ready all 1 -> grants 0,1,2,3,0,... with one result per cycle and no bubbles.
REQ-030 Backpressure: rsp_ready[out_id]=0 for 5 cycles -> req_ready=0, rsp_data stable; on release, a pending request is accepted in the same cycle.
REQ-031 Reset mid-stall: ap_rst_n low while out_vld=1 -> rsp_valid=0 immediately, op_cnt=0, rr_ptr=0.
REQ-032 Counter wrap: preload op_cnt via force to 2^32-1, then one handshake -> op_cnt=0.
